// File: rtl/piece_ctrl.sv
// piece_ctrl: active tetromino controller for a 12x10 playfield.
// Spawns a piece from a free-running LFSR, moves/rotates it against the playfield
// occupancy, applies gravity, and signals lock (bottom_flag) or blocked spawn (top_flag).
// Optional feature macro: HARD_DROP_EN (btn_drop triggers a hard drop to lock).
// Ports:
//   Clk, Reset                     - clock, synchronous active-high reset
//   gen_flag                       - spawn request (accepted in IDLE/OVER)
//   tick                           - gravity pulse
//   btn_left/right/rot/drop        - one-cycle button pulses
//   arr0..arr11 [9:0]              - playfield rows (row 0 top), bit j = column j
//   x1..x4 / y1..y4 [3:0]          - row / column of each active cell (registered)
//   bottom_flag                    - one-cycle lock pulse
//   top_flag                       - spawn blocked (game over)
//   piece_type [2:0]               - 0=I 1=O 2=T 3=S 4=Z 5=J 6=L
//   active                         - piece is falling
module piece_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       gen_flag,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_drop,
  input  logic [9:0] arr0,
  input  logic [9:0] arr1,
  input  logic [9:0] arr2,
  input  logic [9:0] arr3,
  input  logic [9:0] arr4,
  input  logic [9:0] arr5,
  input  logic [9:0] arr6,
  input  logic [9:0] arr7,
  input  logic [9:0] arr8,
  input  logic [9:0] arr9,
  input  logic [9:0] arr10,
  input  logic [9:0] arr11,
  output logic [3:0] x1,
  output logic [3:0] x2,
  output logic [3:0] x3,
  output logic [3:0] x4,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic [3:0] y4,
  output logic       bottom_flag,
  output logic       top_flag,
  output logic [2:0] piece_type,
  output logic       active
);

  localparam int unsigned ROW_W  = 4;   // anchor row 0..11
  localparam int unsigned COL_W  = 5;   // anchor column, two's complement -2..9
  localparam int unsigned XY_W   = 4;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [COL_W-1:0]  SPAWN_COL = 5'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FALL,
    S_OVER
`ifdef HARD_DROP_EN
    , S_DROP
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    r_q, r_d;
  logic [COL_W-1:0]    c_q, c_d;
  logic [1:0]          rot_q, rot_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [3:0][XY_W-1:0] x_q, x_d, y_q, y_d;
  logic                bottom_q, bottom_d;
  logic                top_q, top_d;
  logic                active_q, active_d;
  logic                upd;

  // Occupancy map padded to 16x16: rows 12..15 and columns 10..15 read as occupied,
  // so out-of-range cells fail the same lookup as filled ones.
  logic [15:0][15:0] field;
  always_comb begin
    field     = '1;
    field[0]  = {6'h3F, arr0};
    field[1]  = {6'h3F, arr1};
    field[2]  = {6'h3F, arr2};
    field[3]  = {6'h3F, arr3};
    field[4]  = {6'h3F, arr4};
    field[5]  = {6'h3F, arr5};
    field[6]  = {6'h3F, arr6};
    field[7]  = {6'h3F, arr7};
    field[8]  = {6'h3F, arr8};
    field[9]  = {6'h3F, arr9};
    field[10] = {6'h3F, arr10};
    field[11] = {6'h3F, arr11};
  end

  // Offset {dr,dc} of cell k for a piece type and rotation.
  // Rotations are the closed forms of repeatedly applying (dr,dc)->(dc,n-dr).
  function automatic logic [3:0] cell_off(input logic [TYPE_W-1:0] t,
                                          input logic [1:0] rot,
                                          input logic [1:0] k);
    logic [15:0] tbl;
    logic [3:0]  base;
    logic [1:0]  dr, dc, n;
    case (t)
      3'd1:    tbl = 16'h1256;  // O
      3'd2:    tbl = 16'h1456;  // T
      3'd3:    tbl = 16'h1245;  // S
      3'd4:    tbl = 16'h0156;  // Z
      3'd5:    tbl = 16'h0456;  // J
      3'd6:    tbl = 16'h2456;  // L
      default: tbl = 16'h4567;  // I
    endcase
    case (k)
      2'd0:    base = tbl[15:12];
      2'd1:    base = tbl[11:8];
      2'd2:    base = tbl[7:4];
      default: base = tbl[3:0];
    endcase
    dr = base[3:2];
    dc = base[1:0];
    n  = (t == 3'd0 || t == 3'd7) ? 2'd3 : 2'd2;
    if (t == 3'd1) begin
      cell_off = base;
    end else begin
      case (rot)
        2'd0:    cell_off = {dr, dc};
        2'd1:    cell_off = {dc, 2'(n - dr)};
        2'd2:    cell_off = {2'(n - dr), 2'(n - dc)};
        default: cell_off = {2'(n - dc), dr};
      endcase
    end
  endfunction

  // True when every cell of the candidate lands on a free in-range square.
  function automatic logic fits(input logic [15:0][15:0] f,
                                input logic [TYPE_W-1:0] t,
                                input logic [1:0] rot,
                                input logic [4:0] r,
                                input logic [COL_W-1:0] c);
    logic [3:0] off;
    logic [4:0] row;
    logic [4:0] col;
    fits = 1'b1;
    for (int k = 0; k < 4; k++) begin
      off = cell_off(t, rot, 2'(k));
      row = r + 5'(off[3:2]);
      col = c + COL_W'(off[1:0]);
      if (row[4] || col[4] || f[row[3:0]][col[3:0]]) fits = 1'b0;
    end
  endfunction

  logic [4:0] r_ext;
  logic       fit_cur, fit_down, fit_rot, fit_left, fit_right;

  always_comb begin
    r_ext     = {1'b0, r_q};
    fit_cur   = fits(field, type_q, rot_q, r_ext, c_q);
    fit_down  = fits(field, type_q, rot_q, r_ext + 5'd1, c_q);
    fit_rot   = fits(field, type_q, 2'(rot_q + 2'd1), r_ext, c_q);
    fit_left  = fits(field, type_q, rot_q, r_ext, c_q - COL_W'(1));
    fit_right = fits(field, type_q, rot_q, r_ext, c_q + COL_W'(1));
  end

`ifndef HARD_DROP_EN
  logic unused_drop;
  assign unused_drop = btn_drop;
`endif

  // Next-state, anchor and flag logic.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    rot_d    = rot_q;
    type_d   = type_q;
    top_d    = top_q;
    bottom_d = 1'b0;
    upd      = 1'b0;
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      S_IDLE, S_OVER: begin
        if (gen_flag) begin
          type_d  = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
          rot_d   = 2'd0;
          r_d     = '0;
          c_d     = SPAWN_COL;
          top_d   = 1'b0;
          upd     = 1'b1;
          state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        if (fit_cur) begin
          state_d = S_FALL;
        end else begin
          top_d   = 1'b1;
          state_d = S_OVER;
        end
      end
      S_FALL: begin
        if (tick) begin
          if (fit_down) begin
            r_d = r_q + ROW_W'(1);
            upd = 1'b1;
          end else begin
            bottom_d = 1'b1;
            state_d  = S_IDLE;
          end
`ifdef HARD_DROP_EN
        end else if (btn_drop) begin
          if (fit_down) begin
            r_d     = r_q + ROW_W'(1);
            upd     = 1'b1;
            state_d = S_DROP;
          end else begin
            bottom_d = 1'b1;
            state_d  = S_IDLE;
          end
`endif
        end else if (btn_rot) begin
          if (fit_rot) begin
            rot_d = rot_q + 2'd1;
            upd   = 1'b1;
          end
        end else if (btn_left) begin
          if (fit_left) begin
            c_d = c_q - COL_W'(1);
            upd = 1'b1;
          end
        end else if (btn_right) begin
          if (fit_right) begin
            c_d = c_q + COL_W'(1);
            upd = 1'b1;
          end
        end
      end
`ifdef HARD_DROP_EN
      // Descend one row per cycle, buttons ignored, until the piece rests.
      S_DROP: begin
        if (fit_down) begin
          r_d = r_q + ROW_W'(1);
          upd = 1'b1;
        end else begin
          bottom_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef HARD_DROP_EN
    active_d = (state_d == S_FALL) || (state_d == S_DROP);
`else
    active_d = (state_d == S_FALL);
`endif
  end

  // Cell coordinates follow the anchor only when it changes; otherwise they hold.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] off;
      off = cell_off(type_d, rot_d, 2'(k));
      if (upd) begin
        x_d[k] = r_d + XY_W'(off[3:2]);
        y_d[k] = XY_W'(c_d + COL_W'(off[1:0]));
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      c_q      <= SPAWN_COL;
      rot_q    <= '0;
      type_q   <= '0;
      lfsr_q   <= LFSR_SEED;
      x_q      <= '0;
      y_q      <= '0;
      bottom_q <= 1'b0;
      top_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      rot_q    <= rot_d;
      type_q   <= type_d;
      lfsr_q   <= lfsr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bottom_q <= bottom_d;
      top_q    <= top_d;
      active_q <= active_d;
    end
  end

  assign x1          = x_q[0];
  assign x2          = x_q[1];
  assign x3          = x_q[2];
  assign x4          = x_q[3];
  assign y1          = y_q[0];
  assign y2          = y_q[1];
  assign y3          = y_q[2];
  assign y4          = y_q[3];
  assign bottom_flag = bottom_q;
  assign top_flag    = top_q;
  assign piece_type  = type_q;
  assign active      = active_q;

endmodule

// File: tb/tb_piece_ctrl.sv
// Scoreboard bench for piece_ctrl: stimulus pushes expected output snapshots tagged
// with the cycle they must appear in; a negedge monitor pops and compares them.
module tb_piece_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       gen_flag, tick, btn_left, btn_right, btn_rot, btn_drop;
  logic [9:0] arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11;
  logic [3:0] x1, x2, x3, x4, y1, y2, y3, y4;
  logic       bottom_flag, top_flag, active;
  logic [2:0] piece_type;

  always #5 Clk = ~Clk;

  piece_ctrl dut (
    .Clk(Clk), .Reset(Reset), .gen_flag(gen_flag), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
    .arr0(arr0), .arr1(arr1), .arr2(arr2), .arr3(arr3), .arr4(arr4), .arr5(arr5),
    .arr6(arr6), .arr7(arr7), .arr8(arr8), .arr9(arr9), .arr10(arr10), .arr11(arr11),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .bottom_flag(bottom_flag), .top_flag(top_flag), .piece_type(piece_type), .active(active)
  );

  typedef struct {
    int          cyc;
    string       nm;
    logic [37:0] v;
  } exp_t;

  localparam logic [5:0] B_GEN   = 6'b100000;
  localparam logic [5:0] B_TICK  = 6'b010000;
  localparam logic [5:0] B_ROT   = 6'b001000;
  localparam logic [5:0] B_LEFT  = 6'b000100;
  localparam logic [5:0] B_RIGHT = 6'b000010;
  localparam logic [5:0] B_DROP  = 6'b000001;

  exp_t        exp_q[$];
  exp_t        e;
  logic [37:0] obs;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          bot_cnt = 0;
  int          bot_exp = 0;
  logic [15:0] m;

  // Reference LFSR (taps 16,14,13,11) used only to time spawn requests.
  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (Reset) m = 16'hACE1;
    else       m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
  end

  function automatic logic [2:0] mtype(input logic [15:0] v);
    return (v[2:0] == 3'd7) ? 3'd0 : v[2:0];
  endfunction

  function automatic logic [37:0] mk(input logic act, input logic top, input logic bot,
                                     input logic [2:0] t, input logic [15:0] xs,
                                     input logic [15:0] ys);
    return {act, top, bot, t, xs, ys};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic exp_at(input int d, input string nm, input logic [37:0] v);
    exp_t n;
    int   pos;
    n.cyc = cyc + d;
    n.nm  = nm;
    n.v   = v;
    pos   = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > n.cyc) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, n);
  endtask

  task automatic set_in(input logic [5:0] b);
    {gen_flag, tick, btn_rot, btn_left, btn_right, btn_drop} = b;
  endtask

  // Pulse inputs for one cycle, optionally expecting a snapshot the cycle after.
  task automatic press(input logic [5:0] b, input string nm, input logic [37:0] v,
                       input bit chk);
    set_in(b);
    if (chk) exp_at(1, nm, v);
    step();
    set_in(6'b0);
    step();
  endtask

  task automatic wait_type(input logic [2:0] t);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mtype(m) == t) begin
        found = 1'b1;
        break;
      end
      step();
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL wait_type: lfsr never offered type %0d", t);
    end
  endtask

  // Monitor: compare every snapshot due this cycle; also flag exclusivity.
  always @(negedge Clk) begin
    obs = {active, top_flag, bottom_flag, piece_type, x1, x2, x3, x4, y1, y2, y3, y4};
    if (bottom_flag) bot_cnt++;
    if (!Reset) begin
      tests++;
      if (bottom_flag && top_flag) begin
        fails++;
        $display("FAIL flags_exclusive: bottom_flag=1 top_flag=1 at cycle %0d, required not both", cyc);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      tests++;
      if (e.cyc < cyc) begin
        fails++;
        $display("FAIL %s: snapshot missed (due cycle %0d, now %0d)", e.nm, e.cyc, cyc);
      end else if (obs !== e.v) begin
        fails++;
        $display("FAIL %s: got act=%0b top=%0b bot=%0b type=%0d x=%h y=%h, required act=%0b top=%0b bot=%0b type=%0d x=%h y=%h",
                 e.nm, obs[37], obs[36], obs[35], obs[34:32], obs[31:16], obs[15:0],
                 e.v[37], e.v[36], e.v[35], e.v[34:32], e.v[31:16], e.v[15:0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    set_in(6'b0);
    {arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11} = '0;
    step();
    step();
    exp_at(0, "reset_state", mk(0, 0, 0, 0, 16'h0000, 16'h0000));
    step();
    Reset = 1'b0;
    step();

    // O piece: spawn, gravity to the floor, lock pulse.
    wait_type(3'd1);
    exp_at(2, "o_active", mk(1, 0, 0, 1, 16'h0011, 16'h4545));
    press(B_GEN, "o_spawn", mk(0, 0, 0, 1, 16'h0011, 16'h4545), 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) press(B_TICK, "o_r5", mk(1, 0, 0, 1, 16'h5566, 16'h4545), 1);
      else        press(B_TICK, "o_r10", mk(1, 0, 0, 1, 16'hAABB, 16'h4545), i == 9);
    end
    exp_at(2, "o_lock_end", mk(0, 0, 0, 1, 16'hAABB, 16'h4545));
    press(B_TICK, "o_lock", mk(0, 0, 1, 1, 16'hAABB, 16'h4545), 1);
    bot_exp++;

    // I piece: walls, priorities, blocked rotation, lock.
    wait_type(3'd0);
    exp_at(2, "i_active", mk(1, 0, 0, 0, 16'h1111, 16'h3456));
    press(B_GEN, "", '0, 0);
    for (int i = 0; i < 3; i++)
      press(B_LEFT, "i_c0", mk(1, 0, 0, 0, 16'h1111, 16'h0123), i == 2);
    press(B_LEFT, "i_left_wall", mk(1, 0, 0, 0, 16'h1111, 16'h0123), 1);
    for (int i = 0; i < 6; i++)
      press(B_RIGHT, "i_c6", mk(1, 0, 0, 0, 16'h1111, 16'h6789), i == 5);
    press(B_RIGHT, "i_right_wall", mk(1, 0, 0, 0, 16'h1111, 16'h6789), 1);
    press(B_TICK | B_LEFT, "tick_over_left", mk(1, 0, 0, 0, 16'h2222, 16'h6789), 1);
    press(B_ROT | B_LEFT, "rot_over_left", mk(1, 0, 0, 0, 16'h1234, 16'h8888), 1);
    press(B_RIGHT, "i_rot1_right", mk(1, 0, 0, 0, 16'h1234, 16'h9999), 1);
    press(B_ROT, "i_rot_blocked", mk(1, 0, 0, 0, 16'h1234, 16'h9999), 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) press(B_TICK, "i_lock", mk(0, 0, 1, 0, 16'h89AB, 16'h9999), 1);
      else        press(B_TICK, "i_r8", mk(1, 0, 0, 0, 16'h89AB, 16'h9999), i == 6);
    end
    bot_exp++;

    // Blocked spawn -> game over, then a fresh spawn clears top_flag.
    arr0 = 10'h3FF;
    wait_type(3'd2);
    exp_at(2, "t_over", mk(0, 1, 0, 2, 16'h0111, 16'h4345));
    press(B_GEN, "t_spawn", mk(0, 0, 0, 2, 16'h0111, 16'h4345), 1);
    press(B_TICK | B_LEFT, "over_ignores_btn", mk(0, 1, 0, 2, 16'h0111, 16'h4345), 1);
    arr0 = 10'h000;
    wait_type(3'd4);
    exp_at(2, "z_active", mk(1, 0, 0, 4, 16'h0011, 16'h3445));
    press(B_GEN, "z_spawn_clear_top", mk(0, 0, 0, 4, 16'h0011, 16'h3445), 1);
`ifndef HARD_DROP_EN
    press(B_DROP, "drop_ignored", mk(1, 0, 0, 4, 16'h0011, 16'h3445), 1);
`endif
    press(B_ROT, "z_rot", mk(1, 0, 0, 4, 16'h0112, 16'h5544), 1);

    // Reset wins over a simultaneous move.
    Reset = 1'b1;
    tick  = 1'b1;
    exp_at(1, "reset_mid_move", mk(0, 0, 0, 0, 16'h0000, 16'h0000));
    step();
    Reset = 1'b0;
    tick  = 1'b0;
    step();

`ifdef HARD_DROP_EN
    wait_type(3'd2);
    exp_at(2, "t_active", mk(1, 0, 0, 2, 16'h0111, 16'h4345));
    press(B_GEN, "", '0, 0);
    exp_at(10, "drop_r10", mk(1, 0, 0, 2, 16'hABBB, 16'h4345));
    exp_at(11, "drop_lock", mk(0, 0, 1, 2, 16'hABBB, 16'h4345));
    press(B_DROP, "drop_r1", mk(1, 0, 0, 2, 16'h1222, 16'h4345), 1);
    press(B_LEFT, "", '0, 0);
    for (int i = 0; i < 12; i++) step();
    bot_exp++;
`endif

    for (int i = 0; i < 3; i++) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drained: %0d snapshots pending, required 0", exp_q.size());
    end
    tests++;
    if (bot_cnt != bot_exp) begin
      fails++;
      $display("FAIL bottom_pulses: got %0d cycles with bottom_flag, required %0d", bot_cnt, bot_exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
